data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the CPU's load/store data-memory interface. The CPU side issues a request; this block services it after a fixed, configurable latency and returns a one-cycle acknowledge.
- Holds a word-organised 32-bit memory array with byte-enable writes, plus error signalling for misaligned or out-of-range addresses.
- Sits between the CPU datapath's memory stage and the memory array, so multi-cycle memory timing can be exercised before caches exist.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; legal word index 0..DEPTH_WORDS-1
LATENCY, 4, cycles from request acceptance to ack_o; must be >= 1

Ports:
clk_i  input  1  clock; all logic on the rising edge
rst_i  input  1  reset, synchronous, active-high
req_i  input  1  request valid; accepted only in a cycle where busy_o=0
we_i  input  1  1=store, 0=load; sampled at acceptance
addr_i  input  32  byte address; sampled at acceptance
wdata_i  input  32  store data; sampled at acceptance
be_i  input  4  byte enables for stores (bit n selects wdata_i[8n+7:8n]); ignored for loads
busy_o  output  1  transaction in flight; new requests not accepted
ack_o  output  1  one-cycle pulse; transaction complete
rdata_o  output  32  load data; valid in ack cycle, held until next ack
err_o  output  1  valid only with ack_o; 1 = misaligned or out of range

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE; busy_o=0, ack_o=0, err_o=0, rdata_o=0.
  - Latency counter is cleared.
  - Memory array contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - busy_o=0.
  - If req_i=1 at the edge, capture we_i, addr_i, wdata_i and be_i, load the counter with LATENCY-1, and move to WAIT.
  - If LATENCY=1, move directly to RESP instead.
- WAIT:
  - busy_o=1; the counter decrements each cycle.
  - When the counter reaches 1, move to RESP on the next edge.
  - req_i is ignored.
- RESP:
  - busy_o=1, ack_o=1 for exactly this cycle; next state is IDLE.
  - The access itself is performed on the edge that enters RESP, so rdata_o and err_o are registered and valid while ack_o=1.
- Timing:
  - A request accepted at edge T gives ack_o=1 in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - Minimum spacing between acceptances is LATENCY+1 cycles.
- Requester contract: drop req_i no later than the cycle after ack_o. If req_i is still 1 in the first IDLE cycle, it is a new request.
- Error check, on captured address:
  - err=1 if addr[1:0]!=0, or if the word index addr[31:2] >= DEPTH_WORDS (the full 30-bit index is compared; no truncation or wrap).
  - On error: no array write occurs, rdata_o=0, and the ack is still issued with normal latency.
- Store (no error):
  - For each n with be[n]=1, write byte n of the word at index addr[31:2].
  - Bytes with be[n]=0 are unchanged.
  - be=0000 is a legal no-op store and is still acked.
  - rdata_o keeps its previous value on a store.
- Load (no error): rdata_o gets the array word at index addr[31:2], read at the RESP-entry edge. This reflects all previously acked stores.
- rdata_o holds its value between acks. err_o is 0 outside ack cycles.
- Reset mid-transaction (WAIT or RESP): the transaction is aborted. No write is performed if reset lands before the RESP-entry edge, and no ack is issued for the aborted request.
- Simultaneous req_i and rst_i: reset wins; the request is not captured.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, be=1111, followed by a load of 0x10 (LATENCY=4) -> each ack_o occurs exactly 4 cycles after acceptance; the load returns rdata_o=0xDEADBEEF with err_o=0; busy_o=1 for cycles 1..4.
- Byte enables: store 0x11223344 to 0x20 with be=1111, then 0xAABBCCDD with be=0101, then load 0x20 -> 0x11BB33DD.
- Errors: load 0x22 (misaligned), then store to 0x400 with DEPTH_WORDS=256 -> ack_o with err_o=1 and rdata_o=0 for each; a subsequent load of 0x400-4 (0x3FC) returns its earlier content unchanged.
- Busy rejection: hold req_i=1 continuously with alternating addresses -> acceptances occur every LATENCY+1=5 cycles; requests presented in WAIT/RESP are not captured.
- Reset mid-op: store 0x55 pattern to 0x30, assert rst_i 2 cycles after acceptance -> no ack, busy_o=0 next cycle; a load of 0x30 returns the old value.
- LATENCY=1 build: load accepted at edge T -> ack_o high the very next cycle; back-to-back spacing is 2 cycles.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// CPU load/store data-memory bus between the memory stage (master) and the responder (slave).
interface data_memory_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        busy_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  busy_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output busy_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency data-memory responder: word array with byte-enable stores,
// misalignment/range error reporting and a one-cycle acknowledge.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    data_memory_responder_if.slave  bus
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    req_t            req_q, req_d, acc;
    logic            access;
    logic            acc_err;
    logic [29:0]     acc_idx;
    logic [AW-1:0]   acc_word;

    logic            busy_q;
    logic            ack_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic [31:0]     mem [DEPTH_WORDS];

    // Next-state, capture and access-strobe logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    req_d.we    = bus.we_i;
                    req_d.addr  = bus.addr_i;
                    req_d.wdata = bus.wdata_i;
                    req_d.be    = bus.be_i;
                    cnt_d       = CNT_LOAD;
                    state_d     = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // With single-cycle latency the RESP-entry edge is the capture edge itself
        acc    = (LATENCY == 1) ? req_d : req_q;
        access = !rst_i && (state_d == S_RESP) && (state_q != S_RESP);
    end

    assign acc_idx  = acc.addr[31:2];
    assign acc_word = acc.addr[AW+1:2];
    assign acc_err  = (acc.addr[1:0] != 2'b00) || (acc_idx >= 30'(DEPTH_WORDS));

    // State, captured request and registered responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= (state_d != S_IDLE);
            ack_q   <= access;
            err_q   <= access && acc_err;
            if (access) begin
                if (acc_err) begin
                    rdata_q <= '0;
                end else if (!acc.we) begin
                    rdata_q <= mem[acc_word];
                end
            end
        end
    end

    // Array is deliberately left uninitialised across reset
    always_ff @(posedge clk_i) begin
        if (access && acc.we && !acc_err) begin
            for (int n = 0; n < 4; n++) begin
                if (acc.be[n]) begin
                    mem[acc_word][8*n +: 8] <= acc.wdata[8*n +: 8];
                end
            end
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder: a LATENCY=4 and a LATENCY=1 instance
// checked cycle by cycle against a transaction-level reference model.
module tb_data_memory_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT_A = 4;
    localparam int unsigned LAT_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    data_memory_responder_if bus_a ();
    data_memory_responder_if bus_b ();

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (bus_a.slave)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    // Reference model state, one slot per instance
    logic [31:0] mem_m   [2][DEPTH];
    bit          pend    [2];
    longint      ack_at  [2];
    longint      next_free [2];
    bit          t_we    [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [3:0]  t_be    [2];
    logic [31:0] rdata_m [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned lat(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    // One clock: drive inputs, advance the model, compare every output
    task automatic step(input int d, input bit rst, input bit req, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        bit          exp_ack;
        bit          exp_err;
        bit          exp_busy;
        logic [31:0] mask;
        logic [31:0] word;
        int          idx;
        logic        o_ack, o_busy, o_err;
        logic [31:0] o_rdata;
        string       pfx;

        @(negedge clk);
        if (d == 0) begin
            rst_a = rst; bus_a.req_i = req; bus_a.we_i = we;
            bus_a.addr_i = addr; bus_a.wdata_i = wdata; bus_a.be_i = be;
        end else begin
            rst_b = rst; bus_b.req_i = req; bus_b.we_i = we;
            bus_b.addr_i = addr; bus_b.wdata_i = wdata; bus_b.be_i = be;
        end
        @(posedge clk);
        #1;
        cyc++;

        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            pend[d]      = 1'b0;
            rdata_m[d]   = '0;
            next_free[d] = cyc + 1;
        end else begin
            if (!pend[d] && req && cyc >= next_free[d]) begin
                pend[d]    = 1'b1;
                ack_at[d]  = cyc + longint'(lat(d)) - 1;
                t_we[d]    = we;
                t_addr[d]  = addr;
                t_wdata[d] = wdata;
                t_be[d]    = be;
            end
            if (pend[d] && cyc == ack_at[d]) begin
                exp_ack = 1'b1;
                exp_err = (t_addr[d][1:0] != 2'b00) || ((t_addr[d] >> 2) >= DEPTH);
                idx     = int'(t_addr[d] >> 2);
                if (exp_err) begin
                    rdata_m[d] = '0;
                end else if (t_we[d]) begin
                    mask = '0;
                    for (int n = 0; n < 4; n++) begin
                        if (t_be[d][n]) mask = mask | (32'hFF << (8 * n));
                    end
                    word = mem_m[d][idx];
                    mem_m[d][idx] = (word & ~mask) | (t_wdata[d] & mask);
                end else begin
                    rdata_m[d] = mem_m[d][idx];
                end
                next_free[d] = cyc + 2;
            end
        end
        exp_busy = pend[d];
        if (exp_ack) pend[d] = 1'b0;

        if (d == 0) begin
            o_ack = bus_a.ack_o; o_busy = bus_a.busy_o; o_err = bus_a.err_o; o_rdata = bus_a.rdata_o;
            pfx = "a.";
        end else begin
            o_ack = bus_b.ack_o; o_busy = bus_b.busy_o; o_err = bus_b.err_o; o_rdata = bus_b.rdata_o;
            pfx = "b.";
        end
        chk({pfx, "ack"},   32'(o_ack),  32'(exp_ack));
        chk({pfx, "busy"},  32'(o_busy), 32'(exp_busy));
        chk({pfx, "err"},   32'(o_err),  32'(exp_err));
        chk({pfx, "rdata"}, o_rdata,     rdata_m[d]);
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) step(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Single request, req dropped right after acceptance, run to the next free cycle
    task automatic txn(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
        step(d, 1'b0, 1'b1, we, addr, wdata, be);
        idle(d, int'(lat(d)));
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] a;
        k = $urandom_range(0, 9);
        if (k < 7) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        end else if (k == 7) begin
            a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        end else begin
            a = ($urandom() | 32'h0000_0400) & ~32'h3;
        end
        return a;
    endfunction

    task automatic random_phase(input int d, input int n);
        bit rst;
        bit req;
        for (int i = 0; i < n; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            req = ($urandom_range(0, 99) < 60);
            step(d, rst, req, 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
                 4'($urandom_range(0, 15)));
        end
        idle(d, int'(lat(d)) + 2);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.req_i = 1'b0; bus_a.we_i = 1'b0; bus_a.addr_i = '0; bus_a.wdata_i = '0; bus_a.be_i = '0;
        bus_b.req_i = 1'b0; bus_b.we_i = 1'b0; bus_b.addr_i = '0; bus_b.wdata_i = '0; bus_b.be_i = '0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; ack_at[d] = 0; next_free[d] = 0; rdata_m[d] = '0;
        end

        // LATENCY=4 instance: reset, then give every word a known value
        step(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        step(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            txn(0, 1'b1, 32'(i) << 2, $urandom(), 4'hF);
        end

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("load_deadbeef", bus_a.rdata_o, 32'hDEADBEEF);

        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("be_merge", bus_a.rdata_o, 32'h11BB33DD);

        txn(0, 1'b0, 32'h22, 32'h0, 4'h0);
        txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0);
        txn(0, 1'b1, 32'h34, 32'h0BADF00D, 4'h0);
        txn(0, 1'b0, 32'h34, 32'h0, 4'h0);

        // Continuous req with alternating addresses
        for (int i = 0; i < 25; i++) begin
            step(0, 1'b0, 1'b1, 1'b0, (i % 2 == 1) ? 32'h44 : 32'h40, 32'h0, 4'h0);
        end
        idle(0, 6);

        // Reset two cycles after acceptance aborts the store
        step(0, 1'b0, 1'b1, 1'b1, 32'h30, 32'h55555555, 4'hF);
        idle(0, 1);
        step(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(0, 5);
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0);

        // Reset together with a request: request is dropped
        step(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        idle(0, 5);

        random_phase(0, 500);

        // LATENCY=1 instance
        step(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            txn(1, 1'b1, 32'(i) << 2, $urandom(), 4'hF);
        end
        txn(1, 1'b1, 32'h10, 32'h12345678, 4'hF);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("b.load_12345678", bus_b.rdata_o, 32'h12345678);
        for (int i = 0; i < 10; i++) begin
            step(1, 1'b0, 1'b1, 1'b0, (i % 2 == 1) ? 32'h14 : 32'h10, 32'h0, 4'h0);
        end
        idle(1, 3);
        random_phase(1, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
